// File: rtl/core_writeback_pkg.sv
// Shared core constants and the write-source encoding used for debug tracing.
package core_writeback_pkg;

  localparam int unsigned RegCount   = 16;
  localparam int unsigned RegSize    = 8;
  localparam int unsigned RegPtrSize = 4;

  // Which source drove the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE   = 2'd0,
    WB_ALU    = 2'd1,
    WB_FIFO   = 2'd2,
    WB_BYPASS = 2'd3
  } wb_src_e;

  // Load-sourced writes are the only ones that retire a pending-load bit.
  function automatic logic is_load_src(wb_src_e src);
    return (src == WB_FIFO) || (src == WB_BYPASS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO holding load returns that lost arbitration.
module wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 12,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [Width-1:0] push_data,
  input  logic            pop,
  output logic [Width-1:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Control state, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/core_writeback.sv
// Register-file write arbiter: merges ALU results and load returns onto one
// write port, buffers colliding loads, and tracks pending-load registers.
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int unsigned CORE_NUM     = 0,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REG_COUNT    = RegCount,
  parameter int unsigned REG_SIZE     = RegSize,
  parameter int unsigned REG_PTR_SIZE = RegPtrSize
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_PTR_SIZE-1:0] alu_dst,
  input  logic [REG_SIZE-1:0]     alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [REG_PTR_SIZE-1:0] mem_dst,
  input  logic [REG_SIZE-1:0]     mem_data,
  input  logic                    ld_issue,
  input  logic [REG_PTR_SIZE-1:0] ld_issue_dst,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_0,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_1,
  output logic                    fd_stall,
  output logic                    MW_we,
  output logic [REG_PTR_SIZE-1:0] MW_insn_dst,
  output logic [REG_SIZE-1:0]     W_result
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntryW = REG_PTR_SIZE + REG_SIZE;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  // FIFO interface
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [EntryW-1:0]       fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CntW-1:0]         fifo_count;
  logic [REG_PTR_SIZE-1:0] head_dst;
  logic [REG_SIZE-1:0]     head_data;

  // Arbitration results
  logic                    mem_xfer;
  wb_src_e                 wb_src_d, wb_src_q;
  logic [REG_PTR_SIZE-1:0] wr_dst;
  logic [REG_SIZE-1:0]     wr_data;
  logic [CntW-1:0]         count_after;
  logic                    mem_ready_d, mem_ready_q;

  // Registered write port and scoreboard
  logic [REG_PTR_SIZE-1:0] dst_q;
  logic [REG_SIZE-1:0]     data_q;
  logic [REG_COUNT-1:0]    pend_d, pend_q;

  wb_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({mem_dst, mem_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_dst, head_data} = fifo_rdata;

  // The full term is redundant with registered ready; it keeps a push off a full buffer
  // even if the ready path is ever changed.
  assign mem_xfer = mem_valid && mem_ready_q && !fifo_full;

  // Write select: ALU > FIFO head > bypass. A load that cannot be written now is buffered
  // behind any older buffered loads so returns retire in acceptance order.
  always_comb begin
    wb_src_d  = WB_NONE;
    wr_dst    = '0;
    wr_data   = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_valid) begin
      wb_src_d  = WB_ALU;
      wr_dst    = alu_dst;
      wr_data   = alu_data;
      fifo_push = mem_xfer;
    end else if (!fifo_empty) begin
      wb_src_d  = WB_FIFO;
      wr_dst    = head_dst;
      wr_data   = head_data;
      fifo_pop  = 1'b1;
      fifo_push = mem_xfer;
    end else if (mem_xfer) begin
      wb_src_d  = WB_BYPASS;
      wr_dst    = mem_dst;
      wr_data   = mem_data;
    end
  end

  // Ready is registered from post-push/pop occupancy, so it can never admit an overflow.
  always_comb begin
    count_after = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
    mem_ready_d = (count_after < DepthCnt);
  end

  // Scoreboard next-state: clear on a load write, then set on issue so a newer load wins.
  always_comb begin
    pend_d = pend_q;
    if (is_load_src(wb_src_d)) pend_d[wr_dst] = 1'b0;
    if (ld_issue)              pend_d[ld_issue_dst] = 1'b1;
  end

  // Registered write port, ready flag and scoreboard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_src_q    <= WB_NONE;
      dst_q       <= '0;
      data_q      <= '0;
      mem_ready_q <= 1'b1;
      pend_q      <= '0;
    end else begin
      wb_src_q    <= wb_src_d;
      dst_q       <= wr_dst;
      data_q      <= wr_data;
      mem_ready_q <= mem_ready_d;
      pend_q      <= pend_d;
    end
  end

  assign MW_we       = (wb_src_q != WB_NONE);
  assign MW_insn_dst = dst_q;
  assign W_result    = data_q;
  assign mem_ready   = mem_ready_q;
  assign fd_stall    = pend_q[FD_insn_src_0] | pend_q[FD_insn_src_1];

  // A buffered return must never be dropped: pushes only land on a non-full buffer.
  assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full))
    else $error("core_writeback[%0d]: push into full load buffer", CORE_NUM);

endmodule

// File: tb/tb_core_writeback.sv
// Scoreboard bench for core_writeback: a queue-based reference model predicts every
// register-file write (with its cycle), mem_ready and fd_stall.
module tb_core_writeback;

  localparam int Depth = 4;

  logic       clk;
  logic       reset;
  logic       alu_valid;
  logic [3:0] alu_dst;
  logic [7:0] alu_data;
  logic       mem_valid;
  logic       mem_ready;
  logic [3:0] mem_dst;
  logic [7:0] mem_data;
  logic       ld_issue;
  logic [3:0] ld_issue_dst;
  logic [3:0] src0, src1;
  logic       fd_stall;
  logic       MW_we;
  logic [3:0] MW_insn_dst;
  logic [7:0] W_result;

  core_writeback #(
    .CORE_NUM   (0),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_dst       (alu_dst),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_dst       (mem_dst),
    .mem_data      (mem_data),
    .ld_issue      (ld_issue),
    .ld_issue_dst  (ld_issue_dst),
    .FD_insn_src_0 (src0),
    .FD_insn_src_1 (src1),
    .fd_stall      (fd_stall),
    .MW_we         (MW_we),
    .MW_insn_dst   (MW_insn_dst),
    .W_result      (W_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] dst;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] dst;
    logic [7:0] data;
  } ld_t;

  wr_t exp_q[$];   // expected writes, in order, with the cycle they must appear
  ld_t fq[$];      // model of buffered load returns
  bit  m_ready;
  bit  pend[16];

  // Sender-side offer, held until accepted.
  bit         off_v;
  logic [3:0] off_dst;
  logic [7:0] off_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each presented write against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1) begin
      if (MW_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: dst %0d data %0h at cycle %0d, none expected",
                   MW_insn_dst, W_result, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.dst !== MW_insn_dst || e.data !== W_result) begin
            errors++;
            $display("FAIL write: got dst %0d data %0h cycle %0d expected dst %0d data %0h cycle %0d",
                     MW_insn_dst, W_result, cyc, e.dst, e.data, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missed_write: got MW_we 0 expected dst %0d data %0h at cycle %0d",
                 e.dst, e.data, e.cyc);
      end
    end
  end

  task automatic offer(input logic [3:0] d, input logic [7:0] x);
    off_v    = 1'b1;
    off_dst  = d;
    off_data = x;
  endtask

  // One cycle of stimulus, starting and ending at a negedge; advances the reference model.
  task automatic step(input bit av, input logic [3:0] ad, input logic [7:0] adat,
                      input bit li, input logic [3:0] lid,
                      input logic [3:0] s0, input logic [3:0] s1);
    bit  xfer;
    wr_t w;
    ld_t h;
    src0 = s0;
    src1 = s1;
    #1;
    check("fd_stall", 32'(fd_stall), 32'(pend[s0] | pend[s1]));
    check("mem_ready", 32'(mem_ready), 32'(m_ready));
    alu_valid    = av;
    alu_dst      = ad;
    alu_data     = adat;
    mem_valid    = off_v;
    mem_dst      = off_dst;
    mem_data     = off_data;
    ld_issue     = li;
    ld_issue_dst = lid;
    xfer  = off_v && m_ready;
    w.cyc = cyc + 1;
    if (av) begin
      w.dst  = ad;
      w.data = adat;
      exp_q.push_back(w);
      if (xfer) fq.push_back('{dst: off_dst, data: off_data});
    end else if (fq.size() > 0) begin
      h      = fq.pop_front();
      w.dst  = h.dst;
      w.data = h.data;
      exp_q.push_back(w);
      pend[h.dst] = 1'b0;
      if (xfer) fq.push_back('{dst: off_dst, data: off_data});
    end else if (xfer) begin
      w.dst  = off_dst;
      w.data = off_data;
      exp_q.push_back(w);
      pend[off_dst] = 1'b0;
    end
    if (li) pend[lid] = 1'b1;
    m_ready = (fq.size() < Depth);
    if (xfer) off_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] s0, input logic [3:0] s1);
    step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, s0, s1);
  endtask

  task automatic drive_quiet();
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    mem_valid = 0; mem_dst = 0; mem_data = 0;
    ld_issue = 0; ld_issue_dst = 0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    fq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_ready = 1'b1;
    off_v   = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle; buffered loads and pend are discarded.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    drive_quiet();
    model_clear();
    #1;
    check("rst_MW_we", 32'(MW_we), 32'd0);
    check("rst_MW_insn_dst", 32'(MW_insn_dst), 32'd0);
    check("rst_W_result", 32'(W_result), 32'd0);
    src0 = 4'd4; src1 = 4'd7;
    #1;
    check("rst_fd_stall", 32'(fd_stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    drive_quiet();
    src0 = 0; src1 = 0;
    model_clear();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    check("init_MW_we", 32'(MW_we), 32'd0);
    check("init_MW_insn_dst", 32'(MW_insn_dst), 32'd0);
    check("init_W_result", 32'(W_result), 32'd0);
    check("init_fd_stall", 32'(fd_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(0, 0);
    idle(0, 0);

    // ALU write to r3
    step(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 4'd3, 4'd3);
    idle(4'd3, 4'd0);

    // Load to r7: stall while pending, bypass return clears it
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd0, 4'd0);
    offer(4'd7, 8'hC3);
    step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd7, 4'd0);
    idle(4'd7, 4'd1);
    idle(4'd0, 4'd7);

    // Five ALU cycles while loads 1..5 arrive: buffer fills after four, drains in order
    for (int i = 1; i <= 5; i++) begin
      if (!off_v) offer(4'(i), 8'(8'h10 + i));
      step(1'b1, 4'(8 + i), 8'(8'hA0 + i), 1'b0, 4'd0, 4'd0, 4'd0);
    end
    repeat (8) idle(4'd1, 4'd5);

    // Issue to r2 in the same cycle a load write to r2 retires: the new issue wins
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 4'd0, 4'd0);
    offer(4'd2, 8'h22);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 4'd2, 4'd0);
    idle(4'd2, 4'd0);
    offer(4'd2, 8'h33);
    idle(4'd2, 4'd0);
    idle(4'd2, 4'd0);

    // Pend = 0x00F0 plus three buffered loads, then reset
    for (int i = 4; i <= 7; i++) step(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      offer(4'(i), 8'(8'h60 + i));
      step(1'b1, 4'(12 + i), 8'(8'h70 + i), 1'b0, 4'd0, 4'd4, 4'd7);
    end
    do_reset();
    idle(4'd4, 4'd5);
    idle(4'd6, 4'd7);
    idle(4'd0, 4'd1);
    idle(4'd2, 4'd3);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if (!off_v && $urandom_range(1, 0) == 1) offer(4'($urandom_range(15, 0)), 8'($urandom));
      step($urandom_range(9, 0) < 4, 4'($urandom_range(15, 0)), 8'($urandom),
           $urandom_range(9, 0) < 3, 4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end

    // Drain and confirm every predicted write appeared
    repeat (12) idle(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
